// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage types: ALU operation encoding, operand-A source,
// major opcodes and the operand forwarding rule.
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int OPW      = 4;
   localparam int REGADDRW = 5;

   typedef enum logic [OPW-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_AND  = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      A_RS1  = 2'd0,
      A_ZERO = 2'd1,
      A_PC   = 2'd2
   } a_sel_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   function automatic logic is_shift(input alu_op_e op);
      return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
   endfunction

   // MEM beats WB beats regfile; x0 always reads the regfile value.
   function automatic logic [XLEN-1:0] fwd_pick(
      input logic [REGADDRW-1:0] src,
      input logic [XLEN-1:0]     rf_data,
      input logic                mem_en,
      input logic [REGADDRW-1:0] mem_rd,
      input logic [XLEN-1:0]     mem_data,
      input logic                wb_en,
      input logic [REGADDRW-1:0] wb_rd,
      input logic [XLEN-1:0]     wb_data
   );
      if (src == '0)                  return rf_data;
      if (mem_en && (mem_rd == src))  return mem_data;
      if (wb_en && (wb_rd == src))    return wb_data;
      return rf_data;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode: opcode/funct3/funct7[5] to ALU operation and
// operand source selects.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_b5_i,
   output alu_op_e    alu_op_o,
   output logic       b_is_imm_o,
   output a_sel_e     a_sel_o,
   output logic       illegal_o
);

   // Decode the major opcode, then funct3 for the register/immediate ALU forms.
   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      alu_op_o   = ALU_ADD;
      b_is_imm_o = 1'b0;
      a_sel_o    = A_RS1;
      illegal_o  = 1'b0;
      case (opcode_i)
         OPC_OP, OPC_OP_IMM: begin
            b_is_imm_o = (opcode_i == OPC_OP_IMM);
            case (funct3_i)
               3'b000: alu_op_o = (funct7_b5_i && (opcode_i == OPC_OP)) ? ALU_SUB : ALU_ADD;
               3'b001: alu_op_o = ALU_SLL;
               3'b010: alu_op_o = ALU_SLT;
               3'b011: alu_op_o = ALU_SLTU;
               3'b100: alu_op_o = ALU_XOR;
               3'b101: alu_op_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
               3'b110: alu_op_o = ALU_OR;
               3'b111: alu_op_o = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            a_sel_o    = A_ZERO;
            b_is_imm_o = 1'b1;
         end
         OPC_AUIPC: begin
            a_sel_o    = A_PC;
            b_is_imm_o = 1'b1;
         end
         default: begin
            a_sel_o   = A_ZERO;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes and forwards into the S1 issue register,
// which drives the external ALU, then captures the ALU result into the S2
// (EX/MEM) register behind a valid/ready handshake.
module alu_issue_stage
   import riscv_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [6:0]          in_opcode,
   input  logic [2:0]          in_funct3,
   input  logic                in_funct7_b5,
   input  logic [REGADDRW-1:0] in_rs1_addr,
   input  logic [REGADDRW-1:0] in_rs2_addr,
   input  logic [REGADDRW-1:0] in_rd_addr,
   input  logic [XLEN-1:0]     in_rs1_data,
   input  logic [XLEN-1:0]     in_rs2_data,
   input  logic [XLEN-1:0]     in_imm,
   input  logic [XLEN-1:0]     in_pc,
   input  logic                fwd_mem_en,
   input  logic [REGADDRW-1:0] fwd_mem_rd,
   input  logic [XLEN-1:0]     fwd_mem_data,
   input  logic                fwd_wb_en,
   input  logic [REGADDRW-1:0] fwd_wb_rd,
   input  logic [XLEN-1:0]     fwd_wb_data,
   output logic [OPW-1:0]      alu_op,
   output logic [XLEN-1:0]     operand_a,
   output logic [XLEN-1:0]     operand_b,
   input  logic [XLEN-1:0]     alu_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_result,
   output logic [REGADDRW-1:0] out_rd_addr,
   output logic                out_illegal
);

   alu_op_e             dec_op;
   logic                dec_b_is_imm;
   a_sel_e              dec_a_sel;
   logic                dec_illegal;
   logic [XLEN-1:0]     rs1_val, rs2_val;

   logic                s1_valid_q, s1_valid_d;
   alu_op_e             s1_op_q, s1_op_d;
   logic [XLEN-1:0]     s1_a_q, s1_a_d;
   logic [XLEN-1:0]     s1_b_q, s1_b_d;
   logic [REGADDRW-1:0] s1_rd_q, s1_rd_d;
   logic                s1_ill_q, s1_ill_d;

   logic                out_valid_q, out_valid_d;
   logic [XLEN-1:0]     out_result_q, out_result_d;
   logic [REGADDRW-1:0] out_rd_q, out_rd_d;
   logic                out_ill_q, out_ill_d;

   logic                s2_free, in_fire, s2_fire;

   alu_decoder u_dec (
      .opcode_i    (in_opcode),
      .funct3_i    (in_funct3),
      .funct7_b5_i (in_funct7_b5),
      .alu_op_o    (dec_op),
      .b_is_imm_o  (dec_b_is_imm),
      .a_sel_o     (dec_a_sel),
      .illegal_o   (dec_illegal)
   );

   assign rs1_val = fwd_pick(in_rs1_addr, in_rs1_data, fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_en, fwd_wb_rd, fwd_wb_data);
   assign rs2_val = fwd_pick(in_rs2_addr, in_rs2_data, fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_en, fwd_wb_rd, fwd_wb_data);

   // Ready depends only on registered state and out_ready, never on in_valid.
   assign s2_free  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_free;
   assign in_fire  = in_valid && in_ready && !flush;
   assign s2_fire  = s1_valid_q && s2_free && !flush;

   // S1 next state: load decoded, forwarded operands on accept, else drain or hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_rd_d    = s1_rd_q;
      s1_ill_d   = s1_ill_q;
      if (s2_free) s1_valid_d = 1'b0;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_op_d    = dec_op;
         s1_rd_d    = in_rd_addr;
         s1_ill_d   = dec_illegal;
         case (dec_a_sel)
            A_RS1:   s1_a_d = rs1_val;
            A_PC:    s1_a_d = in_pc;
            default: s1_a_d = '0;
         endcase
         if (dec_illegal)       s1_b_d = '0;
         else if (dec_b_is_imm) s1_b_d = in_imm;
         else                   s1_b_d = rs2_val;
         // Shift amount lives in the low 5 bits; upper bits (funct7 for immediates) are cleared.
         if (is_shift(dec_op)) s1_b_d[XLEN-1:5] = '0;
      end
   end

   // S2 next state: capture the ALU result when S1 holds an entry and S2 can take it.
   always_comb begin
      out_valid_d  = s2_free ? s1_valid_q : out_valid_q;
      out_result_d = out_result_q;
      out_rd_d     = out_rd_q;
      out_ill_d    = out_ill_q;
      if (s2_fire) begin
         out_result_d = s1_ill_q ? '0 : alu_result;
         out_rd_d     = s1_rd_q;
         out_ill_d    = s1_ill_q;
      end
   end

   // Pipeline registers; reset wins over flush, flush kills both valids.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   // NOTE: data registers are reset too, because the ALU inputs and EX/MEM data are visible outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= ALU_ADD;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_rd_q      <= '0;
         s1_ill_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_rd_q     <= '0;
         out_ill_q    <= 1'b0;
      end else begin
         s1_valid_q   <= flush ? 1'b0 : s1_valid_d;
         s1_op_q      <= s1_op_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_rd_q      <= s1_rd_d;
         s1_ill_q     <= s1_ill_d;
         out_valid_q  <= flush ? 1'b0 : out_valid_d;
         out_result_q <= out_result_d;
         out_rd_q     <= out_rd_d;
         out_ill_q    <= out_ill_d;
      end
   end

   assign alu_op      = s1_op_q;
   assign operand_a   = s1_a_q;
   assign operand_b   = s1_b_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_rd_addr = out_rd_q;
   assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases with literal
// expectations, then randomized traffic against a transaction-level model
// (a two-deep in-flight queue with fixed two-cycle latency).
module tb_alu_issue_stage;

   localparam logic [6:0] T_OP     = 7'b0110011;
   localparam logic [6:0] T_OP_IMM = 7'b0010011;
   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_AUIPC  = 7'b0010111;
   // funct3 -> operation for the base (funct7[5]=0) register/immediate forms.
   localparam logic [3:0] F3_OP [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_funct7_b5;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic        fwd_mem_en, fwd_wb_en;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic [3:0]  alu_op;
   logic [31:0] operand_a, operand_b, alu_result;
   logic        out_valid, out_ready, out_illegal;
   logic [31:0] out_result;
   logic [4:0]  out_rd_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
      .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
   );

   // Reference ALU semantics; also serves as the external ALU attached to the DUT.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3: return (a < b) ? 32'd1 : 32'd0;
         4'd4: return a ^ b;
         4'd5: return a | b;
         4'd6: return a & b;
         4'd7: return a << b[4:0];
         4'd8: return a >> b[4:0];
         4'd9: return 32'($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_op, operand_a, operand_b);

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ill;
   } iss_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        ill;
      int          acc;
   } ent_t;

   function automatic logic [31:0] ref_src(input logic [4:0] addr, input logic [31:0] rf);
      if (addr == 5'd0) return rf;
      if (fwd_mem_en && fwd_mem_rd == addr) return fwd_mem_data;
      if (fwd_wb_en && fwd_wb_rd == addr) return fwd_wb_data;
      return rf;
   endfunction

   // What the ALU must see for the instruction currently on the input bus.
   function automatic iss_t ref_issue();
      iss_t r;
      r.op = 4'd0; r.a = 32'd0; r.b = 32'd0; r.ill = 1'b0;
      case (in_opcode)
         T_OP, T_OP_IMM: begin
            r.op = F3_OP[in_funct3];
            if (in_funct7_b5 && in_funct3 == 3'd5) r.op = 4'd9;
            if (in_funct7_b5 && in_funct3 == 3'd0 && in_opcode == T_OP) r.op = 4'd1;
            r.a = ref_src(in_rs1_addr, in_rs1_data);
            r.b = (in_opcode == T_OP_IMM) ? in_imm : ref_src(in_rs2_addr, in_rs2_data);
            if (in_funct3 == 3'd1 || in_funct3 == 3'd5) r.b = {27'd0, r.b[4:0]};
         end
         T_LUI:   r.b = in_imm;
         T_AUIPC: begin r.a = in_pc; r.b = in_imm; end
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state, owned by the compare process.
   ent_t q[$];
   int   cyc = 0;
   bit   started = 1'b0;
   bit   rst_prev = 1'b0;
   bit   s1_chk = 1'b0;
   iss_t s1_exp;
   iss_t cur;
   ent_t e;
   logic exp_ready, exp_ov;

   // Compare on every falling edge, then advance the model across the next rising edge.
   always @(negedge clk) begin
      exp_ready = (q.size() < 2) || out_ready;
      exp_ov    = (q.size() != 0) && (cyc >= q[0].acc + 2);
      if (started) begin
         check("in_ready", 32'(in_ready), 32'(exp_ready));
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov) begin
            check("out_result", out_result, q[0].res);
            check("out_rd_addr", 32'(out_rd_addr), 32'(q[0].rd));
            check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
         end
         if (s1_chk) begin
            check("alu_op", 32'(alu_op), 32'(s1_exp.op));
            check("operand_a", operand_a, s1_exp.a);
            check("operand_b", operand_b, s1_exp.b);
         end
         if (rst_prev) begin
            check("rst_alu_op", 32'(alu_op), 32'd0);
            check("rst_operands", operand_a | operand_b, 32'd0);
            check("rst_out_data", out_result | 32'(out_rd_addr) | 32'(out_illegal), 32'd0);
         end
      end
      s1_chk   = 1'b0;
      rst_prev = rst;
      if (rst || flush) begin
         q.delete();
      end else if (started) begin
         if (exp_ov && out_ready) void'(q.pop_front());
         if (in_valid && exp_ready) begin
            cur   = ref_issue();
            e.res = cur.ill ? 32'd0 : alu_fn(cur.op, cur.a, cur.b);
            e.rd  = in_rd_addr;
            e.ill = cur.ill;
            e.acc = cyc;
            q.push_back(e);
            s1_exp = cur;
            s1_chk = 1'b1;
         end
      end
      if (rst) started = 1'b1;
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; fwd_mem_en = 1'b0; fwd_wb_en = 1'b0;
   endtask

   task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [31:0] pc);
      in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_b5 = f7;
      in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd;
      in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_pc = pc;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      idle();
      put(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      in_valid = 1'b0;
      fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
      step(); step();
      rst = 1'b0;

      // ADD 10 + 15
      put(T_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd7, 32'd10, 32'd15, 32'd0, 32'd0);
      step(); idle();
      check("t1_alu_op", 32'(alu_op), 32'd0);
      check("t1_operand_a", operand_a, 32'd10);
      check("t1_operand_b", operand_b, 32'd15);
      step();
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_result", out_result, 32'h19);
      step();

      // SRA with junk in rs2 upper bits
      put(T_OP, 3'd5, 1'b1, 5'd1, 5'd2, 5'd8, 32'h8000_0000, 32'hFFFF_FF04, 32'd0, 32'd0);
      step(); idle();
      check("t2_alu_op", 32'(alu_op), 32'd9);
      check("t2_operand_b", operand_b, 32'd4);
      step();
      check("t2_out_result", out_result, 32'hF800_0000);
      step();

      // SUB with MEM and WB both hitting rs1: MEM wins
      fwd_mem_en = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'd20;
      fwd_wb_en = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'd99;
      put(T_OP, 3'd0, 1'b1, 5'd3, 5'd4, 5'd9, 32'd1, 32'd15, 32'd0, 32'd0);
      step(); idle();
      check("t3_operand_a", operand_a, 32'd20);
      step();
      check("t3_out_result", out_result, 32'd5);
      // x0 is never forwarded
      fwd_mem_en = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd7;
      put(T_OP, 3'd0, 1'b0, 5'd0, 5'd4, 5'd9, 32'd0, 32'd15, 32'd0, 32'd0);
      step(); idle();
      check("t3_x0_operand_a", operand_a, 32'd0);
      step();
      check("t3_x0_out_result", out_result, 32'd15);
      step();

      // SLT then SLTU with downstream stalled
      out_ready = 1'b0;
      put(T_OP, 3'd2, 1'b0, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFF8, 32'd8, 32'd0, 32'd0);
      step();
      put(T_OP, 3'd3, 1'b0, 5'd1, 5'd2, 5'd11, 32'hFFFF_FFF8, 32'd8, 32'd0, 32'd0);
      check("t4_ready_2nd", 32'(in_ready), 32'd1);
      step(); idle();
      check("t4_ready_full", 32'(in_ready), 32'd0);
      check("t4_slt_held", out_result, 32'd1);
      step();
      check("t4_slt_held2", out_result, 32'd1);
      check("t4_ready_full2", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      check("t4_sltu_valid", 32'(out_valid), 32'd1);
      check("t4_sltu_result", out_result, 32'd0);
      step();

      // flush with S1 and S2 full and a third entry offered
      out_ready = 1'b0;
      put(T_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd12, 32'd1, 32'd2, 32'd0, 32'd0);
      step();
      put(T_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd13, 32'd3, 32'd4, 32'd0, 32'd0);
      step();
      put(T_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd14, 32'd5, 32'd6, 32'd0, 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0; idle(); out_ready = 1'b1;
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      step();
      check("t5_out_valid2", 32'(out_valid), 32'd0);
      step();
      check("t5_out_valid3", 32'(out_valid), 32'd0);

      // illegal, LUI, AUIPC
      put(7'b1110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd5, 32'd77, 32'd88, 32'd99, 32'd0);
      step(); idle(); step();
      check("t6_illegal", 32'(out_illegal), 32'd1);
      check("t6_illegal_result", out_result, 32'd0);
      put(T_LUI, 3'd0, 1'b0, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'h1234_5000, 32'd0);
      step(); idle(); step();
      check("t6_lui", out_result, 32'h1234_5000);
      put(T_AUIPC, 3'd0, 1'b0, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'h0000_1000, 32'h0000_0100);
      step(); idle(); step();
      check("t6_auipc", out_result, 32'h0000_1100);

      // reset mid-stream
      out_ready = 1'b0;
      put(T_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd21, 32'd100, 32'd200, 32'd0, 32'd0);
      step();
      put(T_OP, 3'd6, 1'b0, 5'd1, 5'd2, 5'd22, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'd0, 32'd0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; idle(); out_ready = 1'b1;
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_out_result", out_result, 32'd0);
      check("t6_rst_out_rd", 32'(out_rd_addr), 32'd0);
      check("t6_rst_alu_op", 32'(alu_op), 32'd0);
      check("t6_rst_operand_a", operand_a, 32'd0);
      check("t6_rst_operand_b", operand_b, 32'd0);
      check("t6_rst_in_ready", 32'(in_ready), 32'd1);

      // randomized traffic with stalls, flushes and the odd reset
      for (int i = 0; i < 2000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0, 5:    in_opcode = T_OP;
            1:       in_opcode = T_OP_IMM;
            2:       in_opcode = T_LUI;
            3:       in_opcode = T_AUIPC;
            default: in_opcode = 7'($urandom);
         endcase
         in_funct3    = 3'($urandom);
         in_funct7_b5 = 1'($urandom);
         in_rs1_addr  = 5'($urandom_range(0, 7));
         in_rs2_addr  = 5'($urandom_range(0, 7));
         in_rd_addr   = 5'($urandom);
         in_rs1_data  = $urandom;
         in_rs2_data  = $urandom;
         in_imm       = $urandom;
         in_pc        = $urandom;
         fwd_mem_en   = 1'($urandom);
         fwd_mem_rd   = 5'($urandom_range(0, 7));
         fwd_mem_data = $urandom;
         fwd_wb_en    = 1'($urandom);
         fwd_wb_rd    = 5'($urandom_range(0, 7));
         fwd_wb_data  = $urandom;
         out_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 39) == 0);
         rst          = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0; idle(); out_ready = 1'b1;
      step(); step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
